rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Parametrised N-requester round-robin arbiter. It is the successor to the team's two-requester fixed arbiter and serves as the shared-resource gatekeeper in front of any bus or memory port with several masters. Grants are registered and one-hot. A granted requester keeps the grant for as long as it holds its request, up to a configurable hold limit. After the limit the grant is forced to rotate whenever other requests are pending.

## Interface
- N, default 4, number of requesters; legal range 2..16.
- MAX_HOLD, default 8, maximum consecutive grant cycles while other requests are pending; legal range ≥1.
- clk  input  1  clock; all state changes on the rising edge.
- rest_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high means requester i wants the resource.
- gnt  output  N  one-hot grant, registered; all zero when idle.
- gnt_id  output  max(1,$clog2(N))  binary index of the granted requester; valid only while busy=1, otherwise 0.
- busy  output  1  high whenever any gnt bit is high.

## Operation
- Internal state:
  - FSM with IDLE and GRANT.
  - Rotating priority pointer ptr (width of gnt_id).
  - Holder index hld.
  - Hold counter hcnt, width $clog2(MAX_HOLD+1), saturating at MAX_HOLD.
- Reset (rest_n=0, asynchronous): gnt=0, gnt_id=0, busy=0, state=IDLE, ptr=0, hcnt=0. Outputs clear immediately, without waiting for a clock edge. After reset is released, requester 0 has the highest priority.
- Arbitration function pick(v, p): the first set bit of v, searching upward from index p and wrapping modulo N.
- IDLE:
  - If req≠0 → GRANT. Set hld=pick(req, ptr), gnt=1<<hld, hcnt=1.
  - Otherwise stay in IDLE.
- GRANT, evaluated each edge. Define others = req with bit hld cleared.
  - Keep condition: req[hld]=1 AND (hcnt<MAX_HOLD OR others=0). If it holds, keep the grant and set hcnt=min(hcnt+1, MAX_HOLD).
  - Release (req[hld]=0) or timeout (req[hld]=1, hcnt=MAX_HOLD, others≠0):
    - Set ptr=(hld+1) mod N.
    - If req (after clearing bit hld on release) is nonzero, grant pick(req, (hld+1) mod N) in the same edge with hcnt=1. The hand-over has no idle cycle.
    - Otherwise go to IDLE with gnt=0.
  - On timeout, the old holder can win again only if it is the sole requester. That case cannot occur, because timeout requires others≠0.
- Requests are level-sensitive, with no latching. A request that drops before it is granted is forgotten.
- A request dropped by a non-holder has no effect on the current grant.
- gnt is always one-hot or zero. gnt_id and busy are registered together with gnt.

## Timing
- Latency from req rising (sampled at edge k) to gnt high is one cycle: gnt is visible after edge k.
- Release latency is one cycle: the holder drops req before edge k, and gnt changes at edge k.
- Maximum continuous grant while others are waiting is exactly MAX_HOLD cycles.
- Worst-case wait for any requester that holds its req high is (N−1)·MAX_HOLD cycles.
- If only the holder requests, the grant is held indefinitely and hcnt stays saturated. When a new requester appears, the switch happens at the next edge.
- Reset asserted mid-grant clears outputs combinationally through the asynchronous reset. Release of reset is synchronous to the next edge: the first grant can appear at the first edge after rest_n rises.
- Simultaneous holder release and new requests resolve with a single pick from (hld+1). No cycle is lost.

## Test plan
- Reset: drive req=4'b1111, assert rest_n=0 mid-cycle while gnt=4'b0010 → gnt=0, busy=0, gnt_id=0 before the next edge. After release, the first grant is 4'b0001.
- Single requester: req=4'b0100 from edge 3 to edge 8 → gnt=4'b0100 and gnt_id=2 after edges 3–7. After edge 8, gnt=0 and busy=0.
- Full contention (N=4, MAX_HOLD=4): req=4'b1111 held constant → gnt is 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again.
- Early release hand-over: req=4'b0011, with req[0] dropped after 2 grant cycles → gnt is 0001 for 2 cycles, then 0010 on the next edge with no zero cycle.
- Sole-holder saturation: req=4'b0010 for 10 cycles → gnt=0010 throughout. req[3] rises at cycle 10 → gnt=1000 one edge later, with ptr passing over index 2 because req[2]=0.
- N=2, MAX_HOLD=1 build: req=2'b11 constant → gnt alternates 01, 10, 01 every cycle. gnt_id is 1 bit.

Source files
------------

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : N-requester round-robin arbiter with registered one-hot grant,
//             grant holding while the holder keeps requesting, and a hold
//             limit that forces rotation when other requesters are waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W    = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic            clk,
  input  logic            rest_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [ID_W-1:0]  c_last_id  = ID_W'(N - 1);

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_hld;
  logic [CNT_W-1:0]  r_hcnt;
  logic [N-1:0]      r_gnt;
  logic [ID_W-1:0]   r_gnt_id;
  logic              r_busy;

  logic [N-1:0]      w_hld_mask;
  logic [N-1:0]      w_others;
  logic [N-1:0]      w_req_sh;
  logic              w_hld_req;
  logic              w_keep;
  logic [ID_W-1:0]   w_next_ptr;
  logic [ID_W-1:0]   w_idle_pick;
  logic [ID_W-1:0]   w_hand_pick;

  // One-hot vector with bit i set.
  function automatic logic [N-1:0] f_onehot(input logic [ID_W-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  // First set bit of v searching upward from p, wrapping modulo N.
  function automatic logic [ID_W-1:0] f_pick(input logic [N-1:0] v,
                                             input logic [ID_W-1:0] p);
    logic [ID_W-1:0] res;
    logic            found;
    logic [N-1:0]    sh;
    int              idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(p) + i) % N;
      sh  = v >> idx;
      if (!found && sh[0]) begin
        res   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Holder bookkeeping and next-winner selection.
  always_comb begin
    w_hld_mask  = f_onehot(r_hld);
    w_others    = req & ~w_hld_mask;
    w_req_sh    = req >> r_hld;
    w_hld_req   = w_req_sh[0];
    // Holder keeps the resource until it lets go, or until it has used its
    // full quota while someone else is waiting.
    w_keep      = w_hld_req && ((r_hcnt < c_max_hold) || (w_others == '0));
    w_next_ptr  = (r_hld == c_last_id) ? '0 : r_hld + ID_W'(1);
    w_idle_pick = f_pick(req, r_ptr);
    // On both release and timeout the old holder is excluded; on timeout
    // others is nonzero so the old holder could never win anyway.
    w_hand_pick = f_pick(w_others, w_next_ptr);
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_hld    <= '0;
      r_hcnt   <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != '0) begin
            r_state  <= ST_GRANT;
            r_hld    <= w_idle_pick;
            r_gnt    <= f_onehot(w_idle_pick);
            r_gnt_id <= w_idle_pick;
            r_busy   <= 1'b1;
            r_hcnt   <= c_cnt_one;
          end
        end
        ST_GRANT: begin
          if (w_keep) begin
            if (r_hcnt < c_max_hold) begin
              r_hcnt <= r_hcnt + c_cnt_one;
            end
          end else begin
            r_ptr <= w_next_ptr;
            if (w_others != '0) begin
              // Direct hand-over, no idle cycle in between.
              r_hld    <= w_hand_pick;
              r_gnt    <= f_onehot(w_hand_pick);
              r_gnt_id <= w_hand_pick;
              r_busy   <= 1'b1;
              r_hcnt   <= c_cnt_one;
            end else begin
              r_state  <= ST_IDLE;
              r_gnt    <= '0;
              r_gnt_id <= '0;
              r_busy   <= 1'b0;
              r_hcnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter
//  Brief    : Directed self-checking bench for rr_arbiter (N=4/MAX_HOLD=4 and
//             N=2/MAX_HOLD=1 builds) with an expected-grant scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

  logic       clk;
  logic       rest_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [1:0] req2;
  logic [1:0] gnt2;
  logic [0:0] gnt_id2;
  logic       busy2;

  int checks;
  int errors;

  logic [3:0] sb_q[$];
  logic [1:0] sb2_q[$];

  rr_arbiter #(.N(4), .MAX_HOLD(4)) u_dut4 (
    .clk    (clk),
    .rest_n (rest_n),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  rr_arbiter #(.N(2), .MAX_HOLD(1)) u_dut2 (
    .clk    (clk),
    .rest_n (rest_n),
    .req    (req2),
    .gnt    (gnt2),
    .gnt_id (gnt_id2),
    .busy   (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] f_idx4(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk4(input string tag, input logic [3:0] e);
    checks++;
    assert (gnt === e) else begin
      errors++;
      $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e);
    end
    checks++;
    assert (gnt_id === f_idx4(e)) else begin
      errors++;
      $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, f_idx4(e));
    end
    checks++;
    assert (busy === (e != 4'b0)) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, (e != 4'b0));
    end
  endtask

  // Drive req before an edge, queue the expected grant, check after the edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] e);
    logic [3:0] exp_g;
    @(negedge clk);
    req = r;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    exp_g = sb_q.pop_front();
    chk4(tag, exp_g);
  endtask

  task automatic cyc2(input string tag, input logic [1:0] r, input logic [1:0] e);
    logic [1:0] exp_g;
    logic [0:0] exp_id;
    @(negedge clk);
    req2 = r;
    sb2_q.push_back(e);
    @(posedge clk);
    #1;
    exp_g  = sb2_q.pop_front();
    exp_id = exp_g[1];
    checks++;
    assert (gnt2 === exp_g) else begin
      errors++;
      $error("FAIL %s gnt observed=%b expected=%b", tag, gnt2, exp_g);
    end
    checks++;
    assert (gnt_id2 === exp_id) else begin
      errors++;
      $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id2, exp_id);
    end
    checks++;
    assert (busy2 === (exp_g != 2'b0)) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy2, (exp_g != 2'b0));
    end
  endtask

  initial begin
    logic [3:0] full_seq[17];
    logic [3:0] exp_g;
    checks = 0;
    errors = 0;
    rest_n = 1'b0;
    req    = 4'b0;
    req2   = 2'b0;
    repeat (2) @(posedge clk);
    #1;
    chk4("reset_state", 4'b0000);
    @(negedge clk);
    rest_n = 1'b1;

    // Full contention from ptr=0: 4 cycles each, then back to requester 0.
    for (int i = 0; i < 17; i++) full_seq[i] = 4'b0001 << ((i / 4) % 4);
    for (int i = 0; i < 17; i++) cyc("full_contention", 4'b1111, full_seq[i]);
    cyc("contention_hold", 4'b1111, 4'b0001);
    cyc("contention_hold", 4'b1111, 4'b0001);
    cyc("contention_hold", 4'b1111, 4'b0001);
    cyc("contention_rot", 4'b1111, 4'b0010);

    // Asynchronous reset mid-grant: outputs clear before the next edge.
    #2;
    rest_n = 1'b0;
    #1;
    chk4("async_reset", 4'b0000);
    @(negedge clk);
    rest_n = 1'b1;
    req    = 4'b1111;
    sb_q.push_back(4'b0001);
    @(posedge clk);
    #1;
    exp_g = sb_q.pop_front();
    chk4("first_after_reset", exp_g);
    cyc("release_to_idle", 4'b0000, 4'b0000);

    // Single requester held, then dropped.
    for (int i = 0; i < 5; i++) cyc("single_req", 4'b0100, 4'b0100);
    cyc("single_release", 4'b0000, 4'b0000);

    // Early release hand-over with no idle cycle.
    cyc("early_rel_a", 4'b0011, 4'b0001);
    cyc("early_rel_a", 4'b0011, 4'b0001);
    cyc("early_rel_b", 4'b0010, 4'b0010);
    cyc("early_rel_idle", 4'b0000, 4'b0000);

    // Sole holder saturates, then a newcomer takes over at the next edge.
    for (int i = 0; i < 10; i++) cyc("sole_holder", 4'b0010, 4'b0010);
    cyc("sole_switch", 4'b1010, 4'b1000);
    // Non-holder drop leaves the current grant alone.
    cyc("nonholder_drop", 4'b1000, 4'b1000);
    cyc("sole_idle", 4'b0000, 4'b0000);

    // N=2, MAX_HOLD=1: alternate every cycle.
    cyc2("n2_alt", 2'b11, 2'b01);
    cyc2("n2_alt", 2'b11, 2'b10);
    cyc2("n2_alt", 2'b11, 2'b01);
    cyc2("n2_alt", 2'b11, 2'b10);
    cyc2("n2_alt", 2'b11, 2'b01);
    cyc2("n2_idle", 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
